// File: rtl/tdm_pkg.sv
// Shared TDM framing definitions.
// Used by the serialiser and demultiplexer.
package tdm_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;
  localparam int MISS_W    = 3;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Saturating miss count step.
  function automatic logic [MISS_W-1:0] miss_step(
    input logic [MISS_W-1:0] m,
    input logic [MISS_W-1:0] lim
  );
    return (m >= lim) ? lim : m + 1'b1;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Wrapping slot counter.
// Clear beats load-to-1 beats increment.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load1,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot,
  output logic              address0,
  output logic              address1
);

  // Slot index of the bit expected next.
  always_ff @(posedge clk) begin
    if (reset || clr)
      slot <= '0;
    else if (load1)
      slot <= SLOT_W'(1);
    else if (inc)
      slot <= slot + 1'b1;
  end

  assign address0 = slot[0];
  assign address1 = slot[1];

endmodule

// File: rtl/tdm_demultiplexer.sv
// TDM receive demultiplexer.
// Aligns on frame_sync and emits 4-lane frames.
module tdm_demultiplexer
  import tdm_pkg::*;
#(
  parameter int MISS_LIMIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic serial_in,
  input  logic frame_sync,
  output logic out0,
  output logic out1,
  output logic out2,
  output logic out3,
  output logic address0,
  output logic address1,
  output logic frame_valid,
  output logic sync_error,
  output logic locked
);

  localparam logic [MISS_W-1:0] LIM =
    MISS_W'(MISS_LIMIT);

  state_t              state;
  state_t              state_nxt;
  logic [SLOT_W-1:0]   slot;
  logic [MISS_W-1:0]   miss;
  logic [MISS_W-1:0]   miss_inc;
  logic [2:0]          shadow;

  logic cnt_clr;
  logic cnt_load1;
  logic cnt_inc;
  logic restart;
  logic capture;
  logic complete;
  logic err;
  logic miss_clr;
  logic miss_upd;
  logic c_err;
  logic c_loss;

  tdm_slot_counter u_slot (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .load1    (cnt_load1),
    .inc      (cnt_inc),
    .slot     (slot),
    .address0 (address0),
    .address1 (address1)
  );

  assign miss_inc = miss_step(miss, LIM);
  assign c_err    = frame_sync && (slot != '0);
  assign c_loss   = !frame_sync && (slot == '0)
                 && (miss_inc >= LIM);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= HUNT;
    else
      state <= state_nxt;
  end

  // Next state and datapath controls.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;
    restart   = 1'b0;
    capture   = 1'b0;
    complete  = 1'b0;
    err       = 1'b0;
    miss_clr  = 1'b0;
    miss_upd  = 1'b0;
    unique case (state)
      HUNT: begin
        if (frame_sync) begin
          restart   = 1'b1;
          cnt_load1 = 1'b1;
          miss_clr  = 1'b1;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        unique case (1'b1)
          c_err: begin
            err       = 1'b1;
            restart   = 1'b1;
            cnt_load1 = 1'b1;
            miss_clr  = 1'b1;
          end
          c_loss: begin
            state_nxt = HUNT;
            cnt_clr   = 1'b1;
            miss_upd  = 1'b1;
          end
          default: begin
            capture  = 1'b1;
            cnt_inc  = 1'b1;
            complete = (slot == 2'd3);
            if (slot == '0) begin
              miss_clr = frame_sync;
              miss_upd = !frame_sync;
            end
          end
        endcase
      end
      default: state_nxt = HUNT;
    endcase
  end

  // Shadow, miss counter, lanes and pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow      <= '0;
      miss        <= '0;
      out0        <= 1'b0;
      out1        <= 1'b0;
      out2        <= 1'b0;
      out3        <= 1'b0;
      frame_valid <= 1'b0;
      sync_error  <= 1'b0;
    end else begin
      frame_valid <= complete;
      sync_error  <= err;
      if (miss_clr)
        miss <= '0;
      else if (miss_upd)
        miss <= miss_inc;
      if (restart) begin
        shadow <= {2'b00, serial_in};
      end else if (capture) begin
        case (slot)
          2'd0:    shadow[0] <= serial_in;
          2'd1:    shadow[1] <= serial_in;
          2'd2:    shadow[2] <= serial_in;
          default: ;
        endcase
      end
      if (complete) begin
        out0 <= shadow[0];
        out1 <= shadow[1];
        out2 <= shadow[2];
        out3 <= serial_in;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Bench for tdm_demultiplexer.
// Directed scenarios plus random traffic vs a frame model.
module tb_tdm_demultiplexer;

  localparam int ML = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic serial_in = 1'b0;
  logic frame_sync = 1'b0;
  logic out0, out1, out2, out3;
  logic address0, address1;
  logic frame_valid, sync_error, locked;

  int n_chk  = 0;
  int n_pass = 0;
  int fv_cnt = 0;
  int se_cnt = 0;

  // frame model state
  bit       m_lock;
  int       m_pos;
  int       m_miss;
  bit [3:0] m_bits;
  bit [3:0] m_out;
  bit       m_fv;
  bit       m_se;

  tdm_demultiplexer #(.MISS_LIMIT(ML)) dut (
    .clk         (clk),
    .reset       (reset),
    .serial_in   (serial_in),
    .frame_sync  (frame_sync),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .address0    (address0),
    .address1    (address1),
    .frame_valid (frame_valid),
    .sync_error  (sync_error),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic mdl(input bit rst, input bit fs,
                     input bit sin);
    m_fv = 1'b0;
    m_se = 1'b0;
    if (rst) begin
      m_lock = 0; m_pos = 0; m_miss = 0;
      m_bits = '0; m_out = '0;
    end else if (!m_lock) begin
      if (fs) begin
        m_lock = 1; m_pos = 1; m_miss = 0;
        m_bits = '0; m_bits[0] = sin;
      end
    end else if (fs && m_pos != 0) begin
      m_se = 1; m_pos = 1; m_miss = 0;
      m_bits = '0; m_bits[0] = sin;
    end else begin
      bit drop;
      drop = 0;
      if (m_pos == 0) begin
        if (fs) m_miss = 0;
        else begin
          m_miss = (m_miss + 1 > ML) ? ML : m_miss + 1;
          if (m_miss == ML) drop = 1;
        end
      end
      if (drop) begin
        m_lock = 0; m_pos = 0;
      end else begin
        m_bits[m_pos] = sin;
        if (m_pos == 3) begin
          m_out = m_bits;
          m_fv = 1;
        end
        m_pos = (m_pos + 1) % 4;
      end
    end
  endtask

  task automatic step(input bit rst, input bit fs,
                      input bit sin);
    reset = rst;
    frame_sync = fs;
    serial_in = sin;
    @(posedge clk);
    mdl(rst, fs, sin);
    #1;
    check("lanes", {out3, out2, out1, out0}, m_out);
    check("addr", {address1, address0}, m_pos);
    check("locked", locked, m_lock);
    check("frame_valid", frame_valid, m_fv);
    check("sync_error", sync_error, m_se);
    fv_cnt += int'(frame_valid);
    se_cnt += int'(sync_error);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0);
    fv_cnt = 0;
    se_cnt = 0;
  endtask

  // b[k] is slot k
  task automatic send_frame(input bit [3:0] b,
                            input bit sync);
    for (int i = 0; i < 4; i++)
      step(0, sync && i == 0, b[i]);
  endtask

  initial begin
    // reset state
    do_reset(2);
    check("rst_lanes", {out3, out2, out1, out0}, 4'h0);
    check("rst_locked", locked, 1'b0);

    // basic frame 1,0,1,1
    send_frame(4'b1101, 1);
    check("basic_lanes", {out3, out2, out1, out0},
          4'b1101);
    check("basic_fv", fv_cnt, 1);
    check("basic_lock", locked, 1'b1);

    // no sync
    do_reset(1);
    for (int i = 0; i < 12; i++) step(0, 0, 1);
    check("nosync_lock", locked, 1'b0);
    check("nosync_fv", fv_cnt, 0);
    check("nosync_lanes", {out3, out2, out1, out0},
          4'h0);

    // early sync at slot 2
    do_reset(1);
    send_frame(4'b1111, 1);
    step(0, 1, 1);
    step(0, 0, 1);
    send_frame(4'b0110, 1);
    check("early_se", se_cnt, 1);
    check("early_lanes", {out3, out2, out1, out0},
          4'b0110);
    check("early_fv", fv_cnt, 2);

    // flywheel then loss
    do_reset(1);
    send_frame(4'b1001, 1);
    send_frame(4'b0110, 0);
    check("fly_fv", fv_cnt, 2);
    step(0, 0, 1);
    check("loss_lock", locked, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    check("loss_fv", fv_cnt, 2);
    check("loss_lanes", {out3, out2, out1, out0},
          4'b0110);

    // mid-frame reset
    do_reset(1);
    send_frame(4'b1010, 1);
    step(0, 1, 1);
    step(0, 0, 0);
    step(1, 0, 0);
    check("mrst_lanes", {out3, out2, out1, out0},
          4'h0);
    check("mrst_lock", locked, 1'b0);
    check("mrst_addr", {address1, address0}, 2'd0);
    send_frame(4'b1100, 1);
    check("mrst_frame", {out3, out2, out1, out0},
          4'b1100);

    // back-to-back walking ones
    do_reset(1);
    for (int k = 0; k < 5; k++) begin
      bit [3:0] w;
      w = 4'b0001 << (k % 4);
      send_frame(w, 1);
      check("b2b_lanes", {out3, out2, out1, out0}, w);
    end
    check("b2b_fv", fv_cnt, 5);
    check("b2b_se", se_cnt, 0);

    // random traffic
    do_reset(1);
    for (int i = 0; i < 2000; i++) begin
      bit r, f, s;
      r = ($urandom_range(0, 199) == 0);
      if (m_pos == 0)
        f = ($urandom_range(0, 99) < 75);
      else
        f = ($urandom_range(0, 99) < 4);
      s = 1'($urandom);
      step(r, f, s);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tdm_demultiplexer.md
# tdm_demultiplexer

Receive-side companion to the four-input structural multiplexer. The transmit end drives the multiplexer's address0/address1 from a free-running 2-bit slot counter, which serialises in0..in3 onto one wire. This block recovers frame alignment from a frame_sync strobe and de-serialises each 4-slot frame back onto four registered lanes. It sits at the far end of the serial link and presents complete, aligned frames to downstream logic.

## Interface
- MISS_LIMIT, 2: consecutive frames without frame_sync at slot 0 before lock is dropped; legal range 1..7.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- serial_in  in  1  TDM data bit; one slot per cycle.
- frame_sync  in  1  high during the cycle that carries slot 0.
- out0, out1, out2, out3  out  1 each  registered lane outputs; out_k holds slot k of the last complete frame.
- address0, address1  out  1 each  index of the slot expected next; address0 is the LSB (the same encoding as the multiplexer select). Both are 0 in HUNT.
- frame_valid  out  1  one-cycle pulse when out0..out3 load a new frame.
- sync_error  out  1  one-cycle pulse when frame_sync arrives at a slot other than 0.
- locked  out  1  high while the FSM is in LOCKED.

## Operation
- FSM has two states. HUNT is the reset state; LOCKED is entered on alignment.
- **HUNT, frame_sync=0:** serial_in is ignored and the slot counter stays at 0.
- **HUNT, frame_sync=1:** serial_in is captured as slot 0. The slot counter goes to 1, the miss counter is cleared and the FSM moves to LOCKED.
- **LOCKED, general:** each cycle serial_in is written into shadow bit [slot], and slot increments modulo 4 (3 wraps to 0).
- **LOCKED, slot 3 captured:** out0..out3 load {shadow[0..2], serial_in} on the same edge, and frame_valid is high for the following cycle.
- **LOCKED, slot 0 with frame_sync=1:** normal case. The miss counter clears.
- **LOCKED, slot 0 with frame_sync=0:** the miss counter increments, saturating at MISS_LIMIT.
  - If the new count is below MISS_LIMIT, the bit is captured and the frame proceeds (flywheel).
  - If the new count reaches MISS_LIMIT, the bit is discarded and the FSM goes to HUNT with slot 0. That frame never completes.
- **LOCKED, slot≠0 with frame_sync=1:** sync_error pulses and the partial shadow is discarded. The bit is captured as slot 0, slot becomes 1 and the miss counter clears. The FSM stays LOCKED.
- **Output hold:** out0..out3 hold their values through HUNT and across errors. Only a completed frame or reset changes them.
- **Reset (at any time, including mid-frame):**
  - out0..out3, frame_valid, sync_error, locked, address0, address1 all go to 0.
  - Shadow register and miss counter clear.
  - FSM goes to HUNT.

## Timing
- All outputs are registered, and no combinational path runs from an input to an output.
- Latency: the edge that samples slot 3 updates out0..out3, and frame_valid is high for exactly that next cycle.
- Under continuous alignment, frame_valid pulses every 4 cycles and is never high on two consecutive cycles.
- address0/address1 reflect the slot counter after each edge, and therefore equal the index of the bit expected on the next edge.
- sync_error is asserted in the cycle following the offending edge, for 1 cycle.
- If reset and frame_sync are both high, reset wins.

## Structure
- Shared package `tdm_pkg` holds:
  - NUM_SLOTS = 4 and SLOT_W = 2;
  - the state encoding (HUNT = 1'b0, LOCKED = 1'b1);
  - the miss-counter width MISS_W = 3.
- The transmit-side serialiser uses the same package.
- One sub-module, `tdm_slot_counter`: a 2-bit wrapping counter with synchronous clear and load-to-1, exposing address0/address1.
- FSM, shadow register and lane registers stay in the top level.

## Test plan
- **Basic frame:** reset for 2 cycles, then frame_sync with slot 0, serial bits 1,0,1,1.
  - out0..3 = 1,0,1,1 and frame_valid pulses once, 1 cycle after the slot-3 edge.
  - address1:address0 steps 01,10,11,00; locked = 1.
- **No sync:** after reset, serial_in = 1 and frame_sync = 0 for 12 cycles.
  - locked = 0, outputs stay 0, frame_valid never asserts, address stays 00.
- **Early sync:** lock with frame 1,1,1,1, then pulse frame_sync at slot 2.
  - sync_error pulses once, partial frame discarded.
  - The frame from that point, bits 0,1,1,0, yields out0..3 = 0,1,1,0.
- **Flywheel and loss, MISS_LIMIT=2:**
  - Frame A is 1,0,0,1 with sync; frame B is 0,1,1,0 without sync. Both are delivered.
  - The third slot 0 arrives without sync: locked drops to 0, no frame_valid, outputs hold 0,1,1,0.
- **Mid-frame reset:** lock, send 2 bits, assert reset for 1 cycle.
  - All outputs are 0 and the FSM is in HUNT.
  - A fresh synced frame 0,0,1,1 then delivers 0,0,1,1.
- **Back-to-back:** 5 consecutive synced frames with walking-one patterns.
  - frame_valid exactly every 4th cycle, sync_error never asserts, each lane pattern matches.
